// File: rtl/jellyvl_etherneco_synctimer_pkg.sv
// Shared definitions for the EtherNeco sync-timer responder.
// Contents: responder FSM state enum, command-byte bit indices, and the
// helper that locates a node's slot inside a frame.
package jellyvl_etherneco_synctimer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RES  = 2'd3
   } state_t;

   // Bit positions inside the command byte
   localparam int unsigned CMD_BIT_VALID    = 0;
   localparam int unsigned CMD_BIT_OVERRIDE = 1;

   // Frame position of the first byte of a per-node slot (node is 1-based)
   function automatic logic [15:0] calc_pos(input int unsigned base,
                                            input int unsigned stride,
                                            input logic [7:0]  node);
      return 16'(base + stride * (32'(node) - 32'd1));
   endfunction

endpackage

// File: rtl/jellyvl_etherneco_synctimer_responder_if.sv
// Frame-side bus of the sync-timer responder.
// Carries command/response frame events, the command byte stream, the
// response byte stream and the byte substitution back into the response.
//   master : frame receiver side (drives events and streams)
//   slave  : responder side (drives m_res_data / m_res_valid)
interface jellyvl_etherneco_synctimer_responder_if;

   logic        cmd_rx_start;
   logic        cmd_rx_end;
   logic        cmd_rx_error;
   logic        s_cmd_first;
   logic [15:0] s_cmd_pos;
   logic [7:0]  s_cmd_data;
   logic        s_cmd_valid;

   logic        res_rx_start;
   logic        res_rx_end;
   logic        res_rx_error;
   logic [15:0] s_res_pos;
   logic        s_res_valid;

   logic [7:0]  m_res_data;
   logic        m_res_valid;

   modport master (
      output cmd_rx_start, cmd_rx_end, cmd_rx_error,
      output s_cmd_first, s_cmd_pos, s_cmd_data, s_cmd_valid,
      output res_rx_start, res_rx_end, res_rx_error,
      output s_res_pos, s_res_valid,
      input  m_res_data, m_res_valid
   );

   modport slave (
      input  cmd_rx_start, cmd_rx_end, cmd_rx_error,
      input  s_cmd_first, s_cmd_pos, s_cmd_data, s_cmd_valid,
      input  res_rx_start, res_rx_end, res_rx_error,
      input  s_res_pos, s_res_valid,
      output m_res_data, m_res_valid
   );

endinterface

// File: rtl/jellyvl_etherneco_byte_capture.sv
// Captures a little-endian multi-byte field out of a positioned byte stream.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   enable_i     : capture allowed this cycle
//   base_pos_i   : stream position of byte 0 of the field
//   s_pos_i/s_data_i/s_valid_i : byte stream
//   data_o       : captured field (byte i taken from base_pos_i + i)
module jellyvl_etherneco_byte_capture #(
   parameter int unsigned BYTES = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable_i,
   input  logic [15:0]        base_pos_i,
   input  logic [15:0]        s_pos_i,
   input  logic [7:0]         s_data_i,
   input  logic               s_valid_i,
   output logic [8*BYTES-1:0] data_o
);

   logic [8*BYTES-1:0] data_q;

   // Byte-lane capture
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
      end else if (enable_i && s_valid_i) begin
         for (int i = 0; i < int'(BYTES); i++) begin
            if (s_pos_i == base_pos_i + 16'(i)) begin
               data_q[8*i +: 8] <= s_data_i;
            end
         end
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/jellyvl_etherneco_synctimer_responder.sv
// EtherNeco sync-timer responder node.
// Receives the master time and this node's offset from a command frame,
// requests a timer correction, measures command-to-response turnaround and
// substitutes the measured elapsed time into the response frame.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   current_time      : free-running local time
//   cmd_rx_node       : own node number, 1-based (0 disables the node)
//   bus (slave)       : frame events, byte streams, response substitution
//   correct_override/correct_time/correct_valid : correction request
//   timeout           : one-cycle pulse when no response arrives in time
//   elapsed_time      : last measured turnaround
// Option: JELLYVL_SYNCTIMER_RESPONDER_SEQ_EN adds an 8-bit sequence byte
// after the elapsed field, incremented on every completed response.
module jellyvl_etherneco_synctimer_responder
   import jellyvl_etherneco_synctimer_pkg::*;
#(
   parameter int unsigned TIMER_WIDTH    = 64,
   parameter int unsigned TIME_BYTES     = 8,
   parameter int unsigned OFFSET_BYTES   = 4,
   parameter int unsigned HEADER_BYTES   = 1,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [TIMER_WIDTH-1:0]      current_time,
   input  logic [7:0]                  cmd_rx_node,
   jellyvl_etherneco_synctimer_responder_if.slave bus,
   output logic                        correct_override,
   output logic [TIMER_WIDTH-1:0]      correct_time,
   output logic                        correct_valid,
   output logic                        timeout,
   output logic [8*OFFSET_BYTES-1:0]   elapsed_time
);

   localparam int unsigned OW    = 8 * OFFSET_BYTES;
   localparam int unsigned TMW   = 8 * TIME_BYTES;
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t                 state_q, state_d;
   logic [OW-1:0]          start_q, start_d;
   logic [7:0]             cmd_q, cmd_d;
   logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
   logic [OW-1:0]          elapsed_q, elapsed_d;
   logic                   correct_valid_q, correct_valid_d;
   logic                   correct_override_q, correct_override_d;
   logic [TIMER_WIDTH-1:0] correct_time_q, correct_time_d;
   logic                   timeout_q, timeout_d;
   logic                   m_res_valid_q, m_res_valid_d;
   logic [7:0]             m_res_data_q, m_res_data_d;
`ifdef JELLYVL_SYNCTIMER_RESPONDER_SEQ_EN
   logic [7:0]             seq_q, seq_d;
`endif

   logic                   node_en_c;
   logic                   cap_en_c;
   logic [15:0]            res_base_c;
   logic [15:0]            res_idx_c;
   logic [TMW-1:0]         time_c;
   logic [OW-1:0]          offset_c;

   assign node_en_c  = (cmd_rx_node != 8'd0);
   assign cap_en_c   = node_en_c && (state_q == ST_CMD);
   assign res_base_c = calc_pos(HEADER_BYTES, OFFSET_BYTES, cmd_rx_node);
   // Wraps to a huge value below the slot, so one compare bounds both sides
   assign res_idx_c  = bus.s_res_pos - res_base_c;

   // Master time field
   jellyvl_etherneco_byte_capture #(
      .BYTES (TIME_BYTES)
   ) u_time_cap (
      .clk        (clk),
      .reset      (reset),
      .enable_i   (cap_en_c),
      .base_pos_i (16'(HEADER_BYTES)),
      .s_pos_i    (bus.s_cmd_pos),
      .s_data_i   (bus.s_cmd_data),
      .s_valid_i  (bus.s_cmd_valid),
      .data_o     (time_c)
   );

   // This node's offset field
   jellyvl_etherneco_byte_capture #(
      .BYTES (OFFSET_BYTES)
   ) u_offset_cap (
      .clk        (clk),
      .reset      (reset),
      .enable_i   (cap_en_c),
      .base_pos_i (calc_pos(HEADER_BYTES + TIME_BYTES, OFFSET_BYTES, cmd_rx_node)),
      .s_pos_i    (bus.s_cmd_pos),
      .s_data_i   (bus.s_cmd_data),
      .s_valid_i  (bus.s_cmd_valid),
      .data_o     (offset_c)
   );

   // Next-state and registered-output logic
   always_comb begin
      state_d            = state_q;
      start_d            = start_q;
      cmd_d              = cmd_q;
      wait_cnt_d         = wait_cnt_q;
      elapsed_d          = elapsed_q;
      correct_valid_d    = 1'b0;
      correct_override_d = correct_override_q;
      correct_time_d     = correct_time_q;
      timeout_d          = 1'b0;
      m_res_valid_d      = 1'b0;
      m_res_data_d       = m_res_data_q;
`ifdef JELLYVL_SYNCTIMER_RESPONDER_SEQ_EN
      seq_d              = seq_q;
`endif

      if (bus.cmd_rx_start) begin
         // A new command restarts the exchange from any state
         state_d = ST_CMD;
         start_d = OW'(current_time);
         cmd_d   = '0;
      end else begin
         case (state_q)
            ST_CMD: begin
               if (node_en_c && bus.s_cmd_valid && bus.s_cmd_first) begin
                  cmd_d = bus.s_cmd_data;
               end
               if (bus.cmd_rx_error) begin
                  state_d = ST_IDLE;
               end else if (bus.cmd_rx_end) begin
                  state_d            = ST_WAIT;
                  wait_cnt_d         = '0;
                  correct_valid_d    = cmd_q[CMD_BIT_VALID];
                  correct_override_d = cmd_q[CMD_BIT_OVERRIDE];
                  correct_time_d     = TIMER_WIDTH'(time_c) + TIMER_WIDTH'(offset_c);
               end
            end
            ST_WAIT: begin
               if (bus.res_rx_start) begin
                  state_d   = ST_RES;
                  elapsed_d = OW'(current_time) - start_q;
               end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state_d   = ST_IDLE;
                  timeout_d = 1'b1;
               end else begin
                  wait_cnt_d = wait_cnt_q + CNT_W'(1);
               end
            end
            ST_RES: begin
               if (bus.res_rx_error) begin
                  state_d = ST_IDLE;
               end else begin
                  if (node_en_c && bus.s_res_valid) begin
                     if (res_idx_c < 16'(OFFSET_BYTES)) begin
                        m_res_valid_d = 1'b1;
                        m_res_data_d  = 8'(elapsed_q >> {res_idx_c, 3'b000});
                     end
`ifdef JELLYVL_SYNCTIMER_RESPONDER_SEQ_EN
                     else if (res_idx_c == 16'(OFFSET_BYTES)) begin
                        m_res_valid_d = 1'b1;
                        m_res_data_d  = seq_q;
                     end
`endif
                  end
                  if (bus.res_rx_end) begin
                     state_d = ST_IDLE;
`ifdef JELLYVL_SYNCTIMER_RESPONDER_SEQ_EN
                     seq_d   = seq_q + 8'd1;
`endif
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q            <= ST_IDLE;
         start_q            <= '0;
         cmd_q              <= '0;
         wait_cnt_q         <= '0;
         elapsed_q          <= '0;
         correct_valid_q    <= 1'b0;
         correct_override_q <= 1'b0;
         correct_time_q     <= '0;
         timeout_q          <= 1'b0;
         m_res_valid_q      <= 1'b0;
         m_res_data_q       <= '0;
`ifdef JELLYVL_SYNCTIMER_RESPONDER_SEQ_EN
         seq_q              <= '0;
`endif
      end else begin
         state_q            <= state_d;
         start_q            <= start_d;
         cmd_q              <= cmd_d;
         wait_cnt_q         <= wait_cnt_d;
         elapsed_q          <= elapsed_d;
         correct_valid_q    <= correct_valid_d;
         correct_override_q <= correct_override_d;
         correct_time_q     <= correct_time_d;
         timeout_q          <= timeout_d;
         m_res_valid_q      <= m_res_valid_d;
         m_res_data_q       <= m_res_data_d;
`ifdef JELLYVL_SYNCTIMER_RESPONDER_SEQ_EN
         seq_q              <= seq_d;
`endif
      end
   end

   assign correct_valid    = correct_valid_q;
   assign correct_override = correct_override_q;
   assign correct_time     = correct_time_q;
   assign timeout          = timeout_q;
   assign elapsed_time     = elapsed_q;
   assign bus.m_res_valid  = m_res_valid_q;
   assign bus.m_res_data   = m_res_data_q;

   // Command bits above OVERRIDE and time bits above the elapsed width are not used
   logic unused_bits_c;
   assign unused_bits_c = ^{cmd_q, current_time};

endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_responder.sv
// Directed self-checking bench for jellyvl_etherneco_synctimer_responder.
module tb_jellyvl_etherneco_synctimer_responder;

   localparam int TW = 64;
   localparam int TB = 8;
   localparam int OB = 4;
   localparam int HB = 1;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic [TW-1:0]   current_time;
   logic [7:0]      cmd_rx_node;
   logic            correct_override;
   logic [TW-1:0]   correct_time;
   logic            correct_valid;
   logic            timeout;
   logic [8*OB-1:0] elapsed_time;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] got_data [0:31];
   logic       got_vld  [0:31];
   logic [7:0] exp_seq;

   always #5 clk = ~clk;

   jellyvl_etherneco_synctimer_responder_if bus ();

   jellyvl_etherneco_synctimer_responder #(
      .TIMER_WIDTH    (TW),
      .TIME_BYTES     (TB),
      .OFFSET_BYTES   (OB),
      .HEADER_BYTES   (HB),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .current_time     (current_time),
      .cmd_rx_node      (cmd_rx_node),
      .bus              (bus),
      .correct_override (correct_override),
      .correct_time     (correct_time),
      .correct_valid    (correct_valid),
      .timeout          (timeout),
      .elapsed_time     (elapsed_time)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] cmd_byte(input int p, input logic [7:0] node, input logic [7:0] cmd,
                                           input logic [63:0] tm, input logic [31:0] ofs);
      int ob;
      ob = HB + TB + OB * (int'(node) - 1);
      if (p == 0) return cmd;
      if (p < HB + TB) return tm[8*(p-HB) +: 8];
      if (node != 8'd0 && p >= ob && p < ob + OB) return ofs[8*(p-ob) +: 8];
      return 8'hEE;
   endfunction

   // Full command frame; err_pos >= 0 raises cmd_rx_error at that byte instead of ending
   task automatic send_cmd(input logic [7:0] node, input logic [7:0] cmd, input logic [63:0] tm,
                           input logic [31:0] ofs, input logic [63:0] t_start, input int err_pos);
      int n;
      n = HB + TB + OB * int'(node);
      cmd_rx_node      = node;
      current_time     = t_start;
      bus.cmd_rx_start = 1'b1;
      tick();
      bus.cmd_rx_start = 1'b0;
      for (int p = 0; p < n; p++) begin
         bus.s_cmd_valid = 1'b1;
         bus.s_cmd_pos   = 16'(p);
         bus.s_cmd_first = (p == 0);
         bus.s_cmd_data  = cmd_byte(p, node, cmd, tm, ofs);
         bus.cmd_rx_error = (p == err_pos);
         tick();
         bus.cmd_rx_error = 1'b0;
         if (p == err_pos) break;
      end
      bus.s_cmd_valid = 1'b0;
      bus.s_cmd_first = 1'b0;
      if (err_pos < 0) begin
         bus.cmd_rx_end = 1'b1;
         tick();
         bus.cmd_rx_end = 1'b0;
      end
   endtask

   // Response frame; records substituted bytes per position
   task automatic send_resp(input logic [7:0] node, input logic [63:0] t_resp, input int err_pos);
      int n;
      n = HB + OB * int'(node) + 3;
      for (int i = 0; i < 32; i++) begin
         got_vld[i]  = 1'b0;
         got_data[i] = 8'h00;
      end
      current_time     = t_resp;
      bus.res_rx_start = 1'b1;
      tick();
      bus.res_rx_start = 1'b0;
      for (int p = 0; p < n; p++) begin
         bus.s_res_valid  = 1'b1;
         bus.s_res_pos    = 16'(p);
         bus.res_rx_error = (p == err_pos);
         tick();
         bus.res_rx_error = 1'b0;
         got_vld[p]  = bus.m_res_valid;
         got_data[p] = bus.m_res_data;
      end
      bus.s_res_valid = 1'b0;
      if (err_pos < 0) begin
         bus.res_rx_end = 1'b1;
         tick();
         bus.res_rx_end = 1'b0;
      end
   endtask

   task automatic check_resp(input string tag, input logic [7:0] node, input logic [31:0] el,
                             input logic [7:0] seq);
      int base;
      base = HB + OB * (int'(node) - 1);
      check($sformatf("%s pre vld", tag), 64'(got_vld[base-1]), 64'(1'b0));
      for (int i = 0; i < OB; i++) begin
         check($sformatf("%s vld%0d", tag, i), 64'(got_vld[base+i]), 64'(1'b1));
         check($sformatf("%s byte%0d", tag, i), 64'(got_data[base+i]), 64'(el[8*i +: 8]));
      end
`ifdef JELLYVL_SYNCTIMER_RESPONDER_SEQ_EN
      check($sformatf("%s seq vld", tag), 64'(got_vld[base+OB]), 64'(1'b1));
      check($sformatf("%s seq", tag), 64'(got_data[base+OB]), 64'(seq));
      check($sformatf("%s post vld", tag), 64'(got_vld[base+OB+1]), 64'(1'b0));
`else
      check($sformatf("%s post vld", tag), 64'(got_vld[base+OB]), 64'(1'b0));
      if (seq == 8'hFF) $display("seq tracking wrapped");
`endif
   endtask

   initial begin
      int seen;
      int cnt;
      reset            = 1'b1;
      current_time     = '0;
      cmd_rx_node      = 8'd2;
      bus.cmd_rx_start = 1'b0;
      bus.cmd_rx_end   = 1'b0;
      bus.cmd_rx_error = 1'b0;
      bus.s_cmd_first  = 1'b0;
      bus.s_cmd_pos    = '0;
      bus.s_cmd_data   = '0;
      bus.s_cmd_valid  = 1'b0;
      bus.res_rx_start = 1'b0;
      bus.res_rx_end   = 1'b0;
      bus.res_rx_error = 1'b0;
      bus.s_res_pos    = '0;
      bus.s_res_valid  = 1'b0;
      exp_seq          = 8'd0;
      tick();
      tick();
      check("rst correct_valid", 64'(correct_valid), 64'(1'b0));
      check("rst correct_override", 64'(correct_override), 64'(1'b0));
      check("rst correct_time", correct_time, 64'h0);
      check("rst timeout", 64'(timeout), 64'(1'b0));
      check("rst elapsed", 64'(elapsed_time), 64'h0);
      check("rst m_res_valid", 64'(bus.m_res_valid), 64'(1'b0));
      check("rst m_res_data", 64'(bus.m_res_data), 64'h0);
      reset = 1'b0;
      tick();

      // Basic correction, then turnaround 350 - 100 = 0xFA
      send_cmd(8'd2, 8'h01, 64'h1000, 32'h20, 64'd100, -1);
      check("t1 correct_valid", 64'(correct_valid), 64'(1'b1));
      check("t1 correct_time", correct_time, 64'h1020);
      check("t1 override", 64'(correct_override), 64'(1'b0));
      tick();
      check("t1 pulse width", 64'(correct_valid), 64'(1'b0));
      send_resp(8'd2, 64'd350, -1);
      check("t1 elapsed", 64'(elapsed_time), 64'hFA);
      check_resp("t1", 8'd2, 32'h0000_00FA, exp_seq);
      exp_seq++;

      // Override with wrapping sum; elapsed wraps across 2^32
      send_cmd(8'd2, 8'h03, 64'hFFFF_FFFF_FFFF_FFF0, 32'h20, 64'h5_FFFF_FFF0, -1);
      check("t2 correct_valid", 64'(correct_valid), 64'(1'b1));
      check("t2 correct_time", correct_time, 64'h10);
      check("t2 override", 64'(correct_override), 64'(1'b1));
      tick();
      send_resp(8'd2, 64'h6_0000_0010, -1);
      check("t2 elapsed", 64'(elapsed_time), 64'h20);
      check_resp("t2", 8'd2, 32'h0000_0020, exp_seq);
      exp_seq++;

      // Command error drops the command; the next one (node 3) is processed
      send_cmd(8'd2, 8'h01, 64'h1234, 32'h5, 64'd0, 6);
      check("t3 err no valid", 64'(correct_valid), 64'(1'b0));
      tick();
      check("t3 err no valid2", 64'(correct_valid), 64'(1'b0));
      send_cmd(8'd3, 8'h01, 64'h2000, 32'h100, 64'd1000, -1);
      check("t3 correct_valid", 64'(correct_valid), 64'(1'b1));
      check("t3 correct_time", correct_time, 64'h2100);
      tick();
      send_resp(8'd3, 64'd1000 + 64'h1_0203, -1);
      check("t3 elapsed", 64'(elapsed_time), 64'h1_0203);
      check_resp("t3", 8'd3, 32'h0001_0203, exp_seq);
      exp_seq++;

      // Command with valid bit clear, response aborted by an error
      send_cmd(8'd2, 8'h00, 64'h55, 32'h1, 64'd0, -1);
      check("t4 no valid", 64'(correct_valid), 64'(1'b0));
      tick();
      send_resp(8'd2, 64'd40, 5);
      check("t4 err vld pos5", 64'(got_vld[5]), 64'(1'b0));
      check("t4 err vld pos6", 64'(got_vld[6]), 64'(1'b0));

      // No response: timeout 16 cycles after cmd_rx_end is taken
      send_cmd(8'd2, 8'h01, 64'h10, 32'h1, 64'd0, -1);
      seen = 0;
      for (int i = 0; i < TO - 1; i++) begin
         tick();
         if (timeout) seen++;
      end
      check("t5 early timeout", 64'(seen), 64'd0);
      tick();
      check("t5 timeout pulse", 64'(timeout), 64'(1'b1));
      tick();
      check("t5 timeout width", 64'(timeout), 64'(1'b0));
      send_resp(8'd2, 64'd500, -1);
      cnt = 0;
      for (int i = 0; i < 32; i++) if (got_vld[i]) cnt++;
      check("t5 late resp ignored", 64'(cnt), 64'd0);

      // Node 0 neither corrects nor substitutes
      send_cmd(8'd0, 8'h01, 64'h10, 32'h1, 64'd0, -1);
      check("t6 node0 no valid", 64'(correct_valid), 64'(1'b0));
      tick();
      send_resp(8'd0, 64'd90, -1);
      cnt = 0;
      for (int i = 0; i < 32; i++) if (got_vld[i]) cnt++;
      check("t6 node0 no subst", 64'(cnt), 64'd0);

      // Reset in the middle of a command frame
      cmd_rx_node      = 8'd2;
      current_time     = 64'd7;
      bus.cmd_rx_start = 1'b1;
      tick();
      bus.cmd_rx_start = 1'b0;
      for (int p = 0; p < HB + TB + 2 * OB; p++) begin
         bus.s_cmd_valid = 1'b1;
         bus.s_cmd_pos   = 16'(p);
         bus.s_cmd_first = (p == 0);
         bus.s_cmd_data  = cmd_byte(p, 8'd2, 8'h01, 64'h77, 32'h3);
         tick();
      end
      bus.s_cmd_valid = 1'b0;
      bus.s_cmd_first = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t7 rst elapsed", 64'(elapsed_time), 64'h0);
      check("t7 rst correct_time", correct_time, 64'h0);
      check("t7 rst override", 64'(correct_override), 64'(1'b0));
      bus.cmd_rx_end = 1'b1;
      tick();
      bus.cmd_rx_end = 1'b0;
      check("t7 no valid after rst", 64'(correct_valid), 64'(1'b0));
      exp_seq = 8'd0;

      // Clean exchange after reset
      send_cmd(8'd2, 8'h01, 64'h1000, 32'h20, 64'd10, -1);
      check("t8 correct_valid", 64'(correct_valid), 64'(1'b1));
      check("t8 correct_time", correct_time, 64'h1020);
      tick();
      send_resp(8'd2, 64'd20, -1);
      check("t8 elapsed", 64'(elapsed_time), 64'hA);
      check_resp("t8", 8'd2, 32'h0000_000A, exp_seq);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/jellyvl_etherneco_synctimer_responder.md
JELLYVL_ETHERNECO_SYNCTIMER_RESPONDER -- requirements
Module: jellyvl_etherneco_synctimer_responder

Interface
REQ-001 SHALL have parameter TIMER_WIDTH, default 64: local timer width in bits (multiple of 8, 8..64).
REQ-002 SHALL have parameter TIME_BYTES, default 8: bytes of master time carried in the command.
REQ-003 SHALL have parameter OFFSET_BYTES, default 4: bytes per node for offset and elapsed fields (1..8).
REQ-004 SHALL have parameter HEADER_BYTES, default 1: command-byte count before the time field.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 65535: cycles allowed from cmd_rx_end to res_rx_start.
REQ-006 SHALL have ports `clk` (in, 1, clock) and `reset` (in, 1, reset); single clock; reset synchronous, active-high.
REQ-007 SHALL have port current_time (in, TIMER_WIDTH): free-running local time.
REQ-008 SHALL have ports cmd_rx_start, cmd_rx_end, cmd_rx_error (in, 1 each): command frame events.
REQ-009 SHALL have port cmd_rx_node (in, 8): own node number, 1-based.
REQ-010 SHALL have ports s_cmd_first (in, 1), s_cmd_pos (in, 16), s_cmd_data (in, 8), s_cmd_valid (in, 1): command byte stream.
REQ-011 SHALL have ports res_rx_start, res_rx_end, res_rx_error (in, 1 each): response frame events.
REQ-012 SHALL have ports s_res_pos (in, 16) and s_res_valid (in, 1): response byte stream.
REQ-013 SHALL have ports m_res_data (out, 8) and m_res_valid (out, 1): byte substitution into the response.
REQ-014 SHALL have ports correct_override (out, 1), correct_time (out, TIMER_WIDTH), correct_valid (out, 1): correction request to the synctimer core.
REQ-015 SHALL have ports timeout (out, 1), a pulse, and elapsed_time (out, 8*OFFSET_BYTES): last measured turnaround.

Function
REQ-016 SHALL run FSM IDLE -> CMD on cmd_rx_start; CMD -> WAIT on cmd_rx_end; WAIT -> RES on res_rx_start; RES -> IDLE on res_rx_end.
REQ-017 SHALL latch start_time = current_time[8*OFFSET_BYTES-1:0] on cmd_rx_start, from any state (restart).
REQ-018 SHALL capture the command byte at s_cmd_first and time byte i (LSB first) at s_cmd_pos == HEADER_BYTES+i.
REQ-019 SHALL capture offset byte i at s_cmd_pos == HEADER_BYTES+TIME_BYTES+OFFSET_BYTES*(node-1)+i.
REQ-020 SHALL, on res_rx_start in WAIT, set elapsed_time = current_time low bits - start_time, modulo 2^(8*OFFSET_BYTES).
REQ-021 SHALL, one cycle after cmd_rx_end in CMD, pulse correct_valid = cmd[0] and drive correct_override = cmd[1], with correct_time = zero-extended time + zero-extended offset, modulo 2^TIMER_WIDTH.
REQ-022 SHALL, in RES, drive m_res_valid = 1 and m_res_data = elapsed_time byte i one cycle after s_res_valid with s_res_pos == HEADER_BYTES+OFFSET_BYTES*(node-1)+i; otherwise m_res_valid = 0.
REQ-023 SHALL count cycles in WAIT; on reaching TIMEOUT_CYCLES it SHALL pulse timeout for 1 cycle and go to IDLE.
REQ-024 SHALL, on cmd_rx_error in CMD, go to IDLE with no correct_valid pulse.
REQ-025 SHALL, on res_rx_error in RES, go to IDLE and drop m_res_valid the next cycle.
REQ-026 SHALL ignore response events outside WAIT/RES, and ignore node 0 (no captures, no substitution).
REQ-027 SHALL give cmd_rx_start and an error in the same cycle priority to cmd_rx_start.

Reset
REQ-028 SHALL on reset set state IDLE and drive correct_valid, m_res_valid, timeout, elapsed_time to 0, correct_override to 0, correct_time to 0, and m_res_data to 0.
REQ-029 SHALL abort any frame in progress when reset is asserted mid-frame, with no output pulse.

Configuration
REQ-030 Macro JELLYVL_SYNCTIMER_RESPONDER_SEQ_EN: when defined, an 8-bit sequence counter SHALL increment per completed RES and be sent as an extra byte after the elapsed field (pos +OFFSET_BYTES); when undefined, no counter exists and only OFFSET_BYTES bytes are substituted.

Structure
REQ-031 SHALL define the FSM state enum, command bit indices (VALID = 0, OVERRIDE = 1) and the position-computation function in package jellyvl_etherneco_synctimer_pkg.
REQ-032 SHALL put byte-lane capture in one sub-module, jellyvl_etherneco_byte_capture, parameterised by byte count and instantiated for the time and offset fields.

Verification
REQ-033 Node 2, cmd 0x01, time 0x1000, offset 0x20: correct_valid pulses 1 cycle after cmd_rx_end, correct_time = 0x1020, override 0.
REQ-034 cmd_rx_start at t = 100, res_rx_start at t = 350: bytes 0xFA, 0x00, 0x00, 0x00 substituted at pos 5..8 (HEADER 1, node 2).
REQ-035 No res_rx_start after cmd_rx_end, TIMEOUT_CYCLES = 16: timeout pulses 16 cycles later, and a later response is not substituted.
REQ-036 cmd_rx_error mid-command: no correct_valid; the next clean command is processed normally.
REQ-037 start_time 0xFFFFFFF0, response at low word 0x00000010: elapsed = 0x20.
REQ-038 With SEQ_EN, three full exchanges: the sequence byte reads 0, 1, 2 at pos +4.
